// File: rtl/exec_wb_unit.sv
// Multi-cycle execute/write-back sequencer: latches one instruction, reads operands,
// computes ALU (3 cycles) or shift-add MUL (11 cycles), writes back and updates Z/C.
module exec_wb_unit #(
  parameter int DW = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [3:0]    op,
  input  logic [AW-1:0] rd,
  input  logic [AW-1:0] rs1,
  input  logic [AW-1:0] rs2,
  input  logic [DW-1:0] imm,
  output logic [AW-1:0] read_add1,
  output logic [AW-1:0] read_add2,
  input  logic [DW-1:0] read_data1,
  input  logic [DW-1:0] read_data2,
  output logic          en,
  output logic [AW-1:0] write_add,
  output logic [DW-1:0] datain,
  output logic          done,
  output logic          illegal,
  output logic          zero_flag,
  output logic          carry_flag
);

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DW - 1);

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_NOT = 4'h5;
  localparam logic [3:0] OP_SHL = 4'h6;
  localparam logic [3:0] OP_SHR = 4'h7;
  localparam logic [3:0] OP_MOV = 4'h8;
  localparam logic [3:0] OP_LDI = 4'h9;
  localparam logic [3:0] OP_MUL = 4'hA;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_EXEC = 3'd2,
    S_MUL  = 3'd3,
    S_WB   = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [3:0]      op_q;
  logic [AW-1:0]   rd_q, rs1_q, rs2_q;
  logic [DW-1:0]   imm_q;
  logic [DW-1:0]   a_q, b_q;
  logic [DW-1:0]   res_q;
  logic            c_q;
  logic [2*DW-1:0] p_q;
  logic [CW-1:0]   cnt_q;

  logic [DW-1:0]   alu_res;
  logic            alu_c;
  logic [2*DW-1:0] p_nxt;
  logic            op_illegal;
  logic            op_sets_flags;

  assign op_illegal    = (op_q > OP_MUL);
  assign op_sets_flags = (op_q <= OP_SHR) || (op_q == OP_MUL);

  assign instr_ready = (state_q == S_IDLE);
  assign read_add1   = rs1_q;
  assign read_add2   = rs2_q;
  assign write_add   = rd_q;
  assign datain      = res_q;
  assign done        = (state_q == S_WB);
  assign illegal     = (state_q == S_WB) && op_illegal;
  assign en          = (state_q == S_WB) && !op_illegal;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (instr_valid) state_d = S_READ;
      S_READ: state_d = S_EXEC;
      S_EXEC: state_d = (op_q == OP_MUL) ? S_MUL : S_WB;
      S_MUL:  if (cnt_q == CNT_LAST) state_d = S_WB;
      S_WB:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Single-cycle ALU on the captured operands; carry is the widened top bit.
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    case (op_q)
      OP_ADD: {alu_c, alu_res} = {1'b0, a_q} + {1'b0, b_q};
      OP_SUB: {alu_c, alu_res} = {1'b0, a_q} - {1'b0, b_q};
      OP_AND: alu_res = a_q & b_q;
      OP_OR:  alu_res = a_q | b_q;
      OP_XOR: alu_res = a_q ^ b_q;
      OP_NOT: alu_res = ~a_q;
      OP_SHL: begin alu_res = {a_q[DW-2:0], 1'b0}; alu_c = a_q[DW-1]; end
      OP_SHR: begin alu_res = {1'b0, a_q[DW-1:1]}; alu_c = a_q[0]; end
      OP_MOV: alu_res = a_q;
      OP_LDI: alu_res = imm_q;
      default: alu_res = a_q;
    endcase
  end

  always_comb begin
    p_nxt = p_q;
    if (b_q[cnt_q]) p_nxt = p_q + ({{DW{1'b0}}, a_q} << cnt_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q       <= '0;
      rd_q       <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      imm_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      res_q      <= '0;
      c_q        <= 1'b0;
      p_q        <= '0;
      cnt_q      <= '0;
      zero_flag  <= 1'b0;
      carry_flag <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (instr_valid) begin
            op_q  <= op;
            rd_q  <= rd;
            rs1_q <= rs1;
            rs2_q <= rs2;
            imm_q <= imm;
          end
        end
        S_READ: begin
          a_q <= read_data1;
          b_q <= read_data2;
        end
        S_EXEC: begin
          if (op_q == OP_MUL) begin
            p_q   <= '0;
            cnt_q <= '0;
          end else begin
            res_q <= alu_res;
            c_q   <= alu_c;
          end
        end
        S_MUL: begin
          p_q   <= p_nxt;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            res_q <= p_nxt[DW-1:0];
            c_q   <= |p_nxt[2*DW-1:DW];
          end
        end
        S_WB: begin
          // Flags only move for arithmetic/logic ops that actually retire.
          if (!op_illegal && op_sets_flags) begin
            zero_flag  <= (res_q == '0);
            carry_flag <= c_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
